// File: rtl/jamma_joy_scanner.sv
// ---------------------------------------------------------------------------
// jamma_joy_scanner
//
// Time-multiplexed JAMMA joystick scanner. The two players share one 8-bit
// JJOY bus behind an external mux steered by JSELECT. The scanner selects
// player 1 and lets the bus settle, then samples it. It then selects player 2,
// lets the bus settle again and samples it. Finally it presents both words to
// the arcade core together and pulses scan_done.
//
// Scan sequence, one step per enabled clock:
//   SET1 (N) -> SMP1 (1) -> SET2 (N) -> SMP2 (1) -> UPD (1)   = 2N+3 per scan
//   where N = max(SETTLE_CYCLES, 1).
//
// Build option:
//   JAMMA_DEBOUNCE_EN  When defined, each of the 16 output bits changes only
//                      after DEB_COUNT consecutive scans disagree with it.
//                      When undefined, outputs follow the samples directly and
//                      no debounce logic is built.
//
// Ports:
//   clk        core clock (pclk)
//   rst_n      asynchronous active-low reset
//   ena        clock enable; the scan sequence advances only when 1
//   jjoy       shared joystick bus, active-low {start,b2,b1,up,down,left,right,fire}
//   kbd_joy    keyboard joystick, active-low, merged into player 1 bits [5:0]
//   jselect    bus mux select: 0 = player 1, 1 = player 2
//   joy1/joy2  stable player words, active-low
//   scan_done  one-clock pulse in the cycle that joy1/joy2 take new values
// ---------------------------------------------------------------------------
module jamma_joy_scanner #(
    parameter int SETTLE_CYCLES = 8,
    parameter int DEB_COUNT     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] jjoy,
    input  logic [5:0] kbd_joy,
    output logic       jselect,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       scan_done
);

    // A settle time of 0 would sample while the mux is still switching.
    localparam int N  = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_CW = CW'(N);

    typedef enum logic [2:0] {
        SET1,
        SMP1,
        SET2,
        SMP2,
        UPD
    } state_t;

    state_t        state;
    logic [CW-1:0] settle_cnt;
    logic [CW-1:0] settle_inc;
    logic [7:0]    s1;

    // Both players' words are handled as one 16-bit vector {p2, p1} so the
    // commit is a single assignment and joy1/joy2 can never split.
    logic [15:0]   sample_all;
    logic [15:0]   out_all;
    logic [15:0]   out_nxt;

    assign settle_inc = settle_cnt + 1'b1;
    assign out_all    = {joy2, joy1};

    // The commit happens on the SMP2 edge, so the player-2 word comes straight
    // off the bus while player 1 comes from the earlier SMP1 sample. This puts
    // the new words and scan_done in the same (UPD) cycle.
    assign sample_all = {jjoy, s1};

`ifdef JAMMA_DEBOUNCE_EN
    localparam int DW = (DEB_COUNT < 2) ? 1 : $clog2(DEB_COUNT + 1);

    logic [15:0][DW-1:0] deb_cnt;
    logic [15:0][DW-1:0] deb_nxt;

    // NOTE: combinational blocks assign defaults first and use blocking '=';
    // every path then drives every output, so no latch can be inferred.
    always_comb begin
        out_nxt = out_all;
        deb_nxt = deb_cnt;
        for (int i = 0; i < 16; i++) begin
            if (sample_all[i] == out_all[i]) begin
                deb_nxt[i] = '0;
            end else if (int'(deb_cnt[i]) + 1 >= DEB_COUNT) begin
                // Enough consecutive disagreeing scans: accept the new level.
                out_nxt[i] = sample_all[i];
                deb_nxt[i] = '0;
            end else begin
                deb_nxt[i] = deb_cnt[i] + 1'b1;
            end
        end
    end

    // NOTE: this counter bank is flops, not RAM, so it takes the async reset
    // like any other state; a reset scan must not inherit half-counted bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
        end else if (ena && state == SMP2) begin
            deb_cnt <= deb_nxt;
        end
    end
`else
    assign out_nxt = sample_all;
`endif

    // Scan sequencer. All outputs are registered here.
    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SET1;
            settle_cnt <= '0;
            s1         <= 8'hFF;
            jselect    <= 1'b0;
            joy1       <= 8'hFF;
            joy2       <= 8'hFF;
            scan_done  <= 1'b0;
        end else begin
            // The pulse lasts exactly one clock, even if ena drops in UPD.
            scan_done <= 1'b0;
            if (ena) begin
                unique case (state)
                    SET1: begin
                        settle_cnt <= settle_inc;
                        if (settle_inc == N_CW) state <= SMP1;
                    end
                    SMP1: begin
                        s1         <= jjoy & {2'b11, kbd_joy};
                        settle_cnt <= '0;
                        jselect    <= 1'b1;
                        state      <= SET2;
                    end
                    SET2: begin
                        settle_cnt <= settle_inc;
                        if (settle_inc == N_CW) state <= SMP2;
                    end
                    SMP2: begin
                        {joy2, joy1} <= out_nxt;
                        jselect      <= 1'b0;
                        scan_done    <= 1'b1;
                        state        <= UPD;
                    end
                    UPD: begin
                        settle_cnt <= '0;
                        state      <= SET1;
                    end
                    default: begin
                        settle_cnt <= '0;
                        state      <= SET1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jamma_joy_scanner.sv
// ---------------------------------------------------------------------------
// tb_jamma_joy_scanner
//
// Self-checking bench for jamma_joy_scanner. The JAMMA mux is modelled as a
// continuous assignment: the bus shows player 1 or player 2 depending on
// jselect. The reference model tracks the number of enabled clocks since reset.
// It derives the scan phase from that count arithmetically, and it derives the
// expected words from the history of whole-scan samples. Player inputs change
// only right after a scan_done, so each scan sees one constant pair of words.
// Build with +define+JAMMA_DEBOUNCE_EN to test the debounce variant.
// ---------------------------------------------------------------------------
module tb_jamma_joy_scanner;

    localparam int SETTLE = 8;
    localparam int DEB    = 3;
    localparam int N      = (SETTLE < 1) ? 1 : SETTLE;
    localparam int P      = 2 * N + 3;
`ifdef JAMMA_DEBOUNCE_EN
    localparam int H      = (DEB < 1) ? 1 : DEB;
`else
    localparam int H      = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] p1 = 8'hFF;
    logic [7:0] p2 = 8'hFF;
    logic [5:0] kbd = 6'h3F;
    logic [7:0] jjoy;
    logic       jselect;
    logic       scan_done;
    logic [7:0] joy1;
    logic [7:0] joy2;

    assign jjoy = jselect ? p2 : p1;

    always #5 clk = ~clk;

    jamma_joy_scanner #(
        .SETTLE_CYCLES(SETTLE),
        .DEB_COUNT    (DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .jjoy     (jjoy),
        .kbd_joy  (kbd),
        .jselect  (jselect),
        .joy1     (joy1),
        .joy2     (joy2),
        .scan_done(scan_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    int          e_cnt;        // enabled edges since reset
    int          cyc;          // clocks since reset
    int          first_sd;     // cycle of first scan_done after reset
    int          last_sd;
    int          last_period;
    int          sd_cycles;    // clocks with scan_done high
    logic [15:0] m_out;        // expected {joy2, joy1}
    logic [15:0] hist[$];      // recent whole-scan samples, oldest first

    typedef struct {
        logic [7:0] p1;
        logic [7:0] p2;
        logic [5:0] kbd;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    endtask

    // A bit takes the new level once the last H samples all disagree with it.
    function automatic void model_scan();
        logic [15:0] s;
        bit          flip;
        s = {p2, p1 & {2'b11, kbd}};
        hist.push_back(s);
        if (hist.size() > H) void'(hist.pop_front());
        for (int b = 0; b < 16; b++) begin
            flip = (hist.size() == H);
            foreach (hist[k]) if (hist[k][b] == m_out[b]) flip = 0;
            if (flip) m_out[b] = s[b];
        end
    endfunction

    // One clock: drive ena, then check control and data outputs on the falling edge.
    task automatic step(input logic en);
        int   ph;
        logic exp_js;
        logic exp_sd;
        ena = en;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (en) e_cnt++;
        ph     = e_cnt % P;
        exp_js = (ph >= N + 1) && (ph <= 2 * N + 1);
        exp_sd = en && (ph == 2 * N + 2);
        if (exp_sd) model_scan();
        check("ctrl{jselect,scan_done}", 32'({jselect, scan_done}), 32'({exp_js, exp_sd}));
        check("data{joy2,joy1}", 32'({joy2, joy1}), 32'(m_out));
        if (scan_done) begin
            sd_cycles++;
            if (first_sd < 0) first_sd = cyc;
            if (last_sd >= 0) last_period = cyc - last_sd;
            last_sd = cyc;
        end
    endtask

    // mode 0: ena always 1, mode 1: ena toggles, mode 2: ena random (75% high)
    task automatic run_scans(input int k, input int mode);
        int   got;
        int   guard;
        logic en;
        got   = 0;
        guard = 0;
        while (got < k && guard < (k + 1) * P * 8) begin
            case (mode)
                0:       en = 1'b1;
                1:       en = ~ena;
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            step(en);
            guard++;
            if (scan_done) got++;
        end
        if (got < k) check("scan_timeout", 32'(got), 32'(k));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs", 32'({jselect, scan_done, joy1, joy2}), 32'({2'b00, 16'hFFFF}));
        e_cnt       = 0;
        cyc         = 0;
        first_sd    = -1;
        last_sd     = -1;
        last_period = -1;
        m_out       = 16'hFFFF;
        hist.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int sd_before;

        tbl[0] = '{8'h7E, 8'hBD, 6'h3F, 8'h7E, 8'hBD};
        tbl[1] = '{8'hFF, 8'hFF, 6'h3E, 8'hFE, 8'hFF};
        tbl[2] = '{8'hFF, 8'h00, 6'h00, 8'hC0, 8'h00};
        tbl[3] = '{8'hA5, 8'h5A, 6'h2A, 8'hA0, 8'h5A};
        tbl[4] = '{8'h00, 8'hFF, 6'h3F, 8'h00, 8'hFF};
        sd_cycles = 0;

        #1 rst_n = 1'b0;
        do_reset();

        // Reset release timing with ena held high.
        run_scans(3, 0);
        check("first_scan_done_cycle", 32'(first_sd), 32'(2 * N + 2));
        check("scan_period", 32'(last_period), 32'(P));

        // Table of player/keyboard patterns, each held for H scans.
        foreach (tbl[i]) begin
            p1  = tbl[i].p1;
            p2  = tbl[i].p2;
            kbd = tbl[i].kbd;
            run_scans(H, 0);
            check($sformatf("tbl%0d_joy1", i), 32'(joy1), 32'(tbl[i].e1));
            check($sformatf("tbl%0d_joy2", i), 32'(joy2), 32'(tbl[i].e2));
        end

        // One-scan glitch on player 1 bit 0, then a held change.
        p1 = 8'hFF; p2 = 8'hFF; kbd = 6'h3F;
        run_scans(H, 0);
        p1 = 8'hFE;
        run_scans(1, 0);
        check("glitch_scan_joy1", 32'(joy1), 32'((H > 1) ? 8'hFF : 8'hFE));
        p1 = 8'hFF;
        run_scans(1, 0);
        check("after_glitch_joy1", 32'(joy1), 32'(8'hFF));
        p1 = 8'hFE;
        run_scans(H - 1, 0);
        check("held_before_last_joy1", 32'(joy1), 32'(8'hFF));
        run_scans(1, 0);
        check("held_last_joy1", 32'(joy1), 32'(8'hFE));

        // ena toggling every clock doubles the period; pulse stays one clock.
        sd_before = sd_cycles;
        run_scans(3, 1);
        check("toggle_period", 32'(last_period), 32'(2 * P));
        check("toggle_pulse_clocks", 32'(sd_cycles - sd_before), 32'(3));

        // Randomized words and random clock enable.
        for (int s = 0; s < 150; s++) begin
            if ($urandom_range(0, 1) == 1) begin
                p1  = 8'($urandom);
                p2  = 8'($urandom);
                kbd = 6'($urandom);
            end
            run_scans(1, 2);
        end

        // Reset during SET2 with joy1 at 00, then a clean restart.
        p1 = 8'h00; p2 = 8'h3C; kbd = 6'h3F;
        run_scans(H, 0);
        check("pre_reset_joy1", 32'(joy1), 32'(8'h00));
        for (int g = 0; g < 4 * P && (e_cnt % P) != N + 4; g++) step(1'b1);
        check("in_set2_jselect", 32'(jselect), 32'(1));
        do_reset();
        run_scans(H, 0);
        check("restart_first_scan_done", 32'(first_sd), 32'(2 * N + 2));
        check("restart_joy", 32'({joy2, joy1}), 32'({8'h3C, 8'h00}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
